// File: rtl/gmii_order_tx_if.sv
// Order handshake and GMII transmit bundle for the order framer.
// The slave side is the framer; the master side is the decision source plus the PHY-side sink.
interface gmii_order_tx_if;
  logic        order_valid;
  logic        order_ready;
  logic        order_side;
  logic [31:0] order_price;
  logic [15:0] order_qty;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        tx_busy;
  logic [31:0] frames_sent;

  modport master (
    output order_valid, order_side, order_price, order_qty,
    input  order_ready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frames_sent
  );

  modport slave (
    input  order_valid, order_side, order_price, order_qty,
    output order_ready, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frames_sent
  );
endinterface

// File: rtl/gmii_order_tx.sv
// GMII transmit framer: turns one accepted order into a minimum-size Ethernet II frame
// with a running CRC32, then holds the line idle for the inter-frame gap.
module gmii_order_tx #(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  gmii_order_tx_if.slave bus
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned PRE_LEN   = 7;
  localparam int unsigned HDR_LEN   = 14;
  localparam int unsigned PAY_LEN   = 46;
  localparam int unsigned FCS_LEN   = 4;
  localparam int unsigned FIELD_LEN = 11;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        seq, seq_d;
  logic [31:0]        seq_l, price_l;
  logic [15:0]        qty_l;
  logic               side_l;
  logic [31:0]        crc_q, crc_d;
  logic [7:0]         txd_q, txd_d;
  logic               tx_en_q, tx_en_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [31:0]        frames_q;
  logic               accept, last_fcs;

  logic [HDR_LEN-1:0][7:0]   hdr_bytes;
  logic [FIELD_LEN-1:0][7:0] fld_bytes;
  logic [FCS_LEN-1:0][7:0]   fcs_bytes;
  logic [7:0]                hdr_byte, pay_byte;

  // Reflected CRC32, one byte per call, LSB of the data byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (CRC_POLY & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  assign hdr_bytes = {DST_MAC, SRC_MAC, ETHERTYPE};
  assign fld_bytes = {seq_l, (side_l ? 8'h01 : 8'h02), price_l, qty_l};
  assign fcs_bytes = ~crc_q;
  assign hdr_byte  = hdr_bytes[4'(HDR_LEN - 1) - cnt_q[3:0]];
  assign pay_byte  = (cnt_q < CNT_W'(FIELD_LEN)) ? fld_bytes[4'(FIELD_LEN - 1) - cnt_q[3:0]] : 8'h00;

  // Next state, next wire byte and CRC update for the byte going out this cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    seq_d    = seq;
    crc_d    = crc_q;
    txd_d    = 8'h00;
    tx_en_d  = 1'b0;
    accept   = 1'b0;
    last_fcs = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.order_valid && ready_q) begin
          accept  = 1'b1;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
        if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
          state_d = SFD;
          cnt_d   = '0;
        end
      end
      SFD: begin
        txd_d   = 8'hD5;
        tx_en_d = 1'b1;
        crc_d   = CRC_INIT;
        state_d = HEADER;
        cnt_d   = '0;
      end
      HEADER: begin
        txd_d   = hdr_byte;
        tx_en_d = 1'b1;
        crc_d   = crc32_byte(crc_q, hdr_byte);
        if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
        end
      end
      PAYLOAD: begin
        txd_d   = pay_byte;
        tx_en_d = 1'b1;
        crc_d   = crc32_byte(crc_q, pay_byte);
        if (cnt_q == CNT_W'(PAY_LEN - 1)) begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
      FCS: begin
        txd_d   = fcs_bytes[cnt_q[1:0]];
        tx_en_d = 1'b1;
        if (cnt_q == CNT_W'(FCS_LEN - 1)) begin
          last_fcs = 1'b1;
          state_d  = IFG;
          cnt_d    = '0;
        end
      end
      IFG: begin
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) seq_d = seq + 32'd1;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath, order latch and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seq      <= '0;
      seq_l    <= '0;
      side_l   <= 1'b0;
      price_l  <= '0;
      qty_l    <= '0;
      crc_q    <= CRC_INIT;
      txd_q    <= 8'h00;
      tx_en_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      seq     <= seq_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      if (accept) begin
        seq_l   <= seq;
        side_l  <= bus.order_side;
        price_l <= bus.order_price;
        qty_l   <= bus.order_qty;
      end
      if (last_fcs) frames_q <= frames_q + 32'd1;
    end
  end

  assign bus.order_ready = ready_q;
  assign bus.gmii_txd    = txd_q;
  assign bus.gmii_tx_en  = tx_en_q;
  assign bus.gmii_tx_er  = 1'b0;
  assign bus.tx_busy     = busy_q;
  assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_gmii_order_tx.sv
// Directed bench for gmii_order_tx: expected frames are queued at acceptance and
// compared byte by byte as they appear on the GMII bus.
module tb_gmii_order_tx;
  localparam int unsigned IFG = 12;
  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0200_0000_0001;
  localparam logic [15:0] ET  = 16'h88B5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  gmii_order_tx_if bus ();

  gmii_order_tx #(
    .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ET), .IFG_CYCLES(IFG)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  always #4 sys_clk = ~sys_clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_hi = 0;
  int          rises[$];
  logic [7:0]  exp_q[$];
  logic [31:0] tb_seq = 32'd0;
  bit          abort = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build the whole 72-byte expected frame and queue it.
  task automatic push_frame(input logic [31:0] s, input logic side, input logic [31:0] price,
                            input logic [15:0] qty);
    logic [7:0]   f[72];
    logic [111:0] hdr;
    logic [87:0]  p;
    logic [31:0]  c;
    hdr = {DST, SRC, ET};
    p   = {s, (side ? 8'h01 : 8'h02), price, qty};
    for (int i = 0; i < 7; i++) f[i] = 8'h55;
    f[7] = 8'hD5;
    for (int i = 0; i < 14; i++) f[8 + i] = hdr[111 - 8*i -: 8];
    for (int i = 0; i < 46; i++) f[22 + i] = (i < 11) ? p[87 - 8*i -: 8] : 8'h00;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++) c = crc_model(c, f[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) f[68 + i] = c[8*i +: 8];
    for (int i = 0; i < 72; i++) exp_q.push_back(f[i]);
  endtask

  // Wire monitor: byte compare, frame length and receiver CRC residue.
  initial begin
    logic        prev_en;
    int          len;
    logic [31:0] rx_crc;
    prev_en = 1'b0;
    len     = 0;
    rx_crc  = 32'hFFFF_FFFF;
    forever begin
      @(negedge sys_clk);
      if (bus.gmii_tx_en === 1'b1) begin
        if (prev_en !== 1'b1) begin
          rises.push_back(cyc);
          len    = 0;
          rx_crc = 32'hFFFF_FFFF;
          check("tx_er", 32'(bus.gmii_tx_er), 32'd0);
        end
        if (!abort) begin
          if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
          else check("txd", 32'(bus.gmii_txd), 32'(exp_q.pop_front()));
        end
        if (len >= 8) rx_crc = crc_model(rx_crc, bus.gmii_txd);
        len++;
        last_hi = cyc;
      end else if (prev_en === 1'b1 && !abort) begin
        check("frame_len", 32'(len), 32'd72);
        check("crc_residue", rx_crc, 32'hDEBB_20E3);
      end
      prev_en = bus.gmii_tx_en;
    end
  end

  task automatic send_order(input logic side, input logic [31:0] price, input logic [15:0] qty);
    int n;
    @(negedge sys_clk);
    bus.order_side  = side;
    bus.order_price = price;
    bus.order_qty   = qty;
    bus.order_valid = 1'b1;
    n = 0;
    while (bus.order_ready !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 300) begin
      check("accept_timeout", 32'(n), 32'd0);
      bus.order_valid = 1'b0;
      return;
    end
    push_frame(tb_seq, side, price, qty);
    tb_seq = tb_seq + 32'd1;
    @(negedge sys_clk);
    bus.order_valid = 1'b0;
    bus.order_side  = 1'($urandom);
    bus.order_price = $urandom;
    bus.order_qty   = 16'($urandom);
    check("busy_on_accept", 32'(bus.tx_busy), 32'd1);
    check("en_before_latency", 32'(bus.gmii_tx_en), 32'd0);
    @(negedge sys_clk);
    check("en_after_latency", 32'(bus.gmii_tx_en), 32'd1);
  endtask

  task automatic wait_idle(input bit chk_gap);
    int n;
    n = 0;
    while (bus.order_ready !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(n), 32'd0);
    else if (chk_gap) check("ifg_gap", 32'(cyc - last_hi), 32'(IFG));
  endtask

  initial begin
    #400000;
    $error("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, n0;
    bus.order_valid = 1'b0;
    bus.order_side  = 1'b0;
    bus.order_price = 32'd0;
    bus.order_qty   = 16'd0;

    // Reset values, then quiet line after release.
    repeat (3) @(negedge sys_clk);
    check("rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
    check("rst_txd", 32'(bus.gmii_txd), 32'd0);
    check("rst_ready", 32'(bus.order_ready), 32'd0);
    check("rst_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_frames", bus.frames_sent, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("ready_after_rst", 32'(bus.order_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("idle_quiet", 32'({bus.gmii_tx_en, bus.gmii_txd, bus.order_ready}), 32'({1'b0, 8'h00, 1'b1}));
    end
    check("idle_frames", bus.frames_sent, 32'd0);

    // Single buy, then a sell.
    send_order(1'b1, 32'h0001_86A0, 16'h0064);
    wait_idle(1'b1);
    check("frames_after_buy", bus.frames_sent, 32'd1);
    send_order(1'b0, 32'h0000_1234, 16'h0010);
    wait_idle(1'b1);
    check("frames_after_sell", bus.frames_sent, 32'd2);

    // Valid held high for three orders, fields churned every cycle.
    n0 = rises.size();
    @(negedge sys_clk);
    bus.order_valid = 1'b1;
    acc = 0;
    n   = 0;
    while (acc < 3 && n < 1000) begin
      bus.order_side  = 1'($urandom);
      bus.order_price = $urandom;
      bus.order_qty   = 16'($urandom);
      if (bus.order_ready === 1'b1) begin
        push_frame(tb_seq, bus.order_side, bus.order_price, bus.order_qty);
        tb_seq = tb_seq + 32'd1;
        acc++;
      end
      @(negedge sys_clk);
      n++;
    end
    bus.order_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd3);
    repeat (3) @(negedge sys_clk);
    wait_idle(1'b1);
    check("frames_after_b2b", bus.frames_sent, 32'd5);
    check("b2b_rises", 32'(rises.size() - n0), 32'd3);
    if (rises.size() >= n0 + 3) begin
      check("b2b_spacing0", 32'(rises[n0 + 1] - rises[n0]), 32'd85);
      check("b2b_spacing1", 32'(rises[n0 + 2] - rises[n0 + 1]), 32'd85);
    end

    // Reset in the middle of a frame.
    send_order(1'b1, 32'h0000_00AA, 16'h0005);
    repeat (29) @(posedge sys_clk);
    #1;
    check("pre_rst_en", 32'(bus.gmii_tx_en), 32'd1);
    abort = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
    check("mid_rst_txd", 32'(bus.gmii_txd), 32'd0);
    check("mid_rst_frames", bus.frames_sent, 32'd0);
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    tb_seq = 32'd0;
    abort  = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("ready_after_mid_rst", 32'(bus.order_ready), 32'd1);
    check("frames_after_mid_rst", bus.frames_sent, 32'd0);
    send_order(1'b0, 32'h0BAD_F00D, 16'h00FF);
    wait_idle(1'b1);
    check("frames_post_rst", bus.frames_sent, 32'd1);

    // Sequence counter wrap.
    force dut.seq = 32'hFFFF_FFFF;
    @(posedge sys_clk);
    @(negedge sys_clk);
    release dut.seq;
    tb_seq = 32'hFFFF_FFFF;
    send_order(1'b1, 32'h1234_5678, 16'hABCD);
    wait_idle(1'b1);
    send_order(1'b0, 32'h8765_4321, 16'h0001);
    wait_idle(1'b1);
    check("frames_after_wrap", bus.frames_sent, 32'd3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
